deinterleaver: RTL and testbench

//  Receive-side inverse of the turbo-code QPP interleaver. Accepts an interleaved bit stream one bit per

---
 rtl/deinterleaver.sv | 226 ++++++++++++++++++++++
 tb/tb_deinterleaver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver.sv
// QPP turbo-code deinterleaver: bit k of an interleaved block is written to address pi(k) of a
// ping-pong bank, then the full bank is streamed out in natural order. Status ports: DEINT_STATUS_EN.
module deinterleaver #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int AW      = 13,
  parameter int F1_S    = 17,
  parameter int F2_S    = 66,
  parameter int F1_L    = 263,
  parameter int F2_L    = 480
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        block_start_i,
  input  logic        blocksize_i,
  input  logic        data_in_i,
  input  logic        data_valid_i,
  output logic        in_ready_o,
  output logic        data_out_o,
  output logic        data_ready_o,
  output logic        done_o
`ifdef DEINT_STATUS_EN
  ,
  output logic        err_o,
  output logic [15:0] blk_count_o
`endif
);

  localparam int SW = $clog2(K_SMALL);
  localparam int LW = $clog2(K_LARGE);

  localparam logic [AW-1:0] KMAX_S = AW'(K_SMALL - 1);
  localparam logic [AW-1:0] KMAX_L = AW'(K_LARGE - 1);

  localparam logic W_IDLE  = 1'b0;
  localparam logic W_FILL  = 1'b1;
  localparam logic R_IDLE  = 1'b0;
  localparam logic R_DRAIN = 1'b1;

  // Permutation tables, evaluated at elaboration; 64-bit math keeps f2*k*k from overflowing.
  logic [AW-1:0] rom_s [K_SMALL];
  logic [AW-1:0] rom_l [K_LARGE];

  for (genvar i = 0; i < K_SMALL; i++) begin : g_rom_s
    localparam longint PI = (longint'(F1_S) * i + longint'(F2_S) * i * i) % K_SMALL;
    assign rom_s[i] = AW'(PI);
  end

  for (genvar i = 0; i < K_LARGE; i++) begin : g_rom_l
    localparam longint PI = (longint'(F1_L) * i + longint'(F2_L) * i * i) % K_LARGE;
    assign rom_l[i] = AW'(PI);
  end

  // Write side
  logic          w_state_q, w_state_d;
  logic [AW-1:0] k_q, k_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] k_idx;
  logic          sz_idx;
  logic          accept;

  // Write pipeline: one stage to line up with the ROM lookup
  logic          wv_q, wv_d;
  logic          wlast_q, wlast_d;
  logic          wd_q;
  logic          wb_q;
  logic [AW-1:0] wa_q, wa_d;

  // Read side
  logic          r_state_q, r_state_d;
  logic [AW-1:0] r_q, r_d;
  logic          rd_bank_q, rd_bank_d;
  logic          r_last;
  logic          dout_q, dout_d;
  logic          drdy_q, drdy_d;
  logic          done_q, done_d;

  logic          mem0_q [K_LARGE];
  logic          mem1_q [K_LARGE];

  assign in_ready_o = ~full_q[wr_bank_q];
  assign accept     = data_valid_i & in_ready_o;

  always_comb begin
    w_state_d = w_state_q;
    k_d       = k_q;
    wr_bank_d = wr_bank_q;
    size_d    = size_q;
    wv_d      = 1'b0;
    wlast_d   = 1'b0;
    k_idx     = k_q;
    sz_idx    = size_q[wr_bank_q];
    if (accept) begin
      if (block_start_i) begin
        // Fresh start or abort-restart: same bank, size re-sampled.
        size_d[wr_bank_q] = blocksize_i;
        sz_idx            = blocksize_i;
        k_idx             = '0;
        k_d               = AW'(1);
        w_state_d         = W_FILL;
        wv_d              = 1'b1;
      end else if (w_state_q == W_FILL) begin
        wv_d = 1'b1;
        if (k_q == (size_q[wr_bank_q] ? KMAX_L : KMAX_S)) begin
          wlast_d   = 1'b1;
          wr_bank_d = ~wr_bank_q;
          k_d       = '0;
          w_state_d = W_IDLE;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
    end
    wa_d = sz_idx ? rom_l[k_idx[LW-1:0]] : rom_s[k_idx[SW-1:0]];
  end

  always_comb begin
    full_d    = full_q;
    r_state_d = r_state_q;
    r_d       = r_q;
    rd_bank_d = rd_bank_q;
    drdy_d    = 1'b0;
    done_d    = 1'b0;
    dout_d    = 1'b0;
    r_last    = (r_q == (size_q[rd_bank_q] ? KMAX_L : KMAX_S));
    // Full is raised together with the last RAM write so the drain never sees stale data.
    if (wv_q && wlast_q) full_d[wb_q] = 1'b1;
    case (r_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          r_state_d = R_DRAIN;
          r_d       = '0;
        end
      end
      default: begin
        drdy_d = 1'b1;
        dout_d = rd_bank_q ? mem1_q[r_q[LW-1:0]] : mem0_q[r_q[LW-1:0]];
        if (r_last) begin
          done_d            = 1'b1;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          r_d               = '0;
          if (!full_q[~rd_bank_q]) r_state_d = R_IDLE;
        end else begin
          r_d = r_q + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      k_q       <= '0;
      wr_bank_q <= 1'b0;
      size_q    <= '0;
      full_q    <= '0;
      wv_q      <= 1'b0;
      wlast_q   <= 1'b0;
      wd_q      <= 1'b0;
      wb_q      <= 1'b0;
      wa_q      <= '0;
      r_state_q <= R_IDLE;
      r_q       <= '0;
      rd_bank_q <= 1'b0;
      dout_q    <= 1'b0;
      drdy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      k_q       <= k_d;
      wr_bank_q <= wr_bank_d;
      size_q    <= size_d;
      full_q    <= full_d;
      wv_q      <= wv_d;
      wlast_q   <= wlast_d;
      wd_q      <= data_in_i;
      wb_q      <= wr_bank_q;
      wa_q      <= wa_d;
      r_state_q <= r_state_d;
      r_q       <= r_d;
      rd_bank_q <= rd_bank_d;
      dout_q    <= dout_d;
      drdy_q    <= drdy_d;
      done_q    <= done_d;
    end
  end

  // Bank storage carries no reset; contents are only read after a complete fill.
  always_ff @(posedge clk_i) begin
    if (wv_q) begin
      if (wb_q) mem1_q[wa_q[LW-1:0]] <= wd_q;
      else      mem0_q[wa_q[LW-1:0]] <= wd_q;
    end
  end

  assign data_out_o   = dout_q;
  assign data_ready_o = drdy_q;
  assign done_o       = done_q;

`ifdef DEINT_STATUS_EN
  logic        abort;
  logic        err_q, err_d;
  logic [15:0] blk_q, blk_d;

  assign abort = accept & block_start_i & (w_state_q == W_FILL);
  assign err_d = abort | (data_valid_i & ~in_ready_o);
  assign blk_d = done_d ? blk_q + 16'd1 : blk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      blk_q <= '0;
    end else begin
      err_q <= err_d;
      blk_q <= blk_d;
    end
  end

  assign err_o       = err_q;
  assign blk_count_o = blk_q;
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for deinterleaver: single-bit blocks with hand-computed pi(k), back-to-back
// ping-pong, abort, mid-drain reset and interleave/deinterleave loopback.
module tb_deinterleaver;
  localparam int KS = 1056;
  localparam int KL = 6144;

  typedef struct {
    bit sz;
    int kin;
    int exp_idx;
  } vec_t;

  logic clk_i         = 1'b0;
  logic rst_ni        = 1'b0;
  logic block_start_i = 1'b0;
  logic blocksize_i   = 1'b0;
  logic data_in_i     = 1'b0;
  logic data_valid_i  = 1'b0;
  logic in_ready_o, data_out_o, data_ready_o, done_o;
`ifdef DEINT_STATUS_EN
  logic        err_o;
  logic [15:0] blk_count_o;
`endif

  deinterleaver dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .block_start_i (block_start_i),
    .blocksize_i   (blocksize_i),
    .data_in_i     (data_in_i),
    .data_valid_i  (data_valid_i),
    .in_ready_o    (in_ready_o),
    .data_out_o    (data_out_o),
    .data_ready_o  (data_ready_o),
    .done_o        (done_o)
`ifdef DEINT_STATUS_EN
    ,
    .err_o         (err_o),
    .blk_count_o   (blk_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic got_q [$];
  int   gcyc_q [$];
  int   done_pos [$];
  int   bad_done = 0;
  int   err_cnt  = 0;

  always @(negedge clk_i) begin
    if (data_ready_o) begin
      got_q.push_back(data_out_o);
      gcyc_q.push_back(cyc);
      if (done_o) done_pos.push_back(got_q.size());
    end else if (done_o) begin
      bad_done <= bad_done + 1;
    end
`ifdef DEINT_STATUS_EN
    if (err_o) err_cnt <= err_cnt + 1;
`endif
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit vec  [KL];
  bit expv [KL];
  int last_acc = 0;
  int stalls   = 0;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  function automatic int pi(input int k, input bit sz);
    longint kk = k;
    longint m  = sz ? 6144 : 1056;
    longint f1 = sz ? 263 : 17;
    longint f2 = sz ? 480 : 66;
    return int'((f1 * kk + f2 * kk * kk) % m);
  endfunction

  task automatic send_bit(input bit bs, input bit sz, input bit d);
    bit rdy;
    int guard;
    block_start_i = bs;
    blocksize_i   = sz;
    data_in_i     = d;
    data_valid_i  = 1'b1;
    guard = 0;
    do begin
      @(negedge clk_i);
      rdy = in_ready_o;
      @(posedge clk_i);
      #1;
      if (!rdy) begin
        stalls++;
        guard++;
      end
    end while (!rdy && guard < 20000);
    if (!rdy) check("send_timeout", 0, 1);
    last_acc = cyc;
  endtask

  task automatic send_block(input bit sz, input int n);
    for (int k = 0; k < n; k++) send_bit(k == 0, sz, vec[k]);
  endtask

  task automatic idle();
    data_valid_i  = 1'b0;
    block_start_i = 1'b0;
    data_in_i     = 1'b0;
  endtask

  task automatic set_one(input int kin);
    for (int i = 0; i < KL; i++) vec[i] = 1'b0;
    vec[kin] = 1'b1;
  endtask

  task automatic wait_out(input string name, input int target);
    int g = 0;
    while (got_q.size() < target && g < 20000) begin
      @(posedge clk_i);
      #1;
      g++;
    end
    repeat (6) @(posedge clk_i);
    #1;
    check({name, "_beats"}, got_q.size(), target);
  endtask

  // one_idx >= 0: block expected all zero except that index; otherwise compare against expv.
  task automatic check_block(input string name, input int base, input int k, input int one_idx);
    int mism  = 0;
    bit found = 1'b0;
    bit e;
    if (got_q.size() < base + k) begin
      check({name, "_short"}, got_q.size(), base + k);
      return;
    end
    for (int i = 0; i < k; i++) begin
      e = (one_idx < 0) ? expv[i] : (i == one_idx);
      if (got_q[base + i] !== e) mism++;
    end
    check({name, "_bits"}, mism, 0);
    check({name, "_span"}, gcyc_q[base + k - 1] - gcyc_q[base], k - 1);
    foreach (done_pos[j]) if (done_pos[j] == base + k) found = 1'b1;
    check({name, "_done_last"}, int'(found), 1);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_data_ready", int'(data_ready_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_in_ready", int'(in_ready_o), 1);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
`ifdef DEINT_STATUS_EN
    check("rst_blk_count", int'(blk_count_o), 0);
`endif
  endtask

  initial begin
    vec_t tbl [5];
    int base, sa, sb, sc, e0, g;

    tbl[0] = '{1'b0, 1,    83};
    tbl[1] = '{1'b0, 2,    298};
    tbl[2] = '{1'b0, 0,    0};
    tbl[3] = '{1'b0, 1055, 49};
    tbl[4] = '{1'b1, 1,    743};

    repeat (3) @(posedge clk_i);
    #1;
    check("init_data_ready", int'(data_ready_o), 0);
    check("init_done", int'(done_o), 0);
    check("init_in_ready", int'(in_ready_o), 1);
`ifdef DEINT_STATUS_EN
    check("init_err", int'(err_o), 0);
    check("init_blk_count", int'(blk_count_o), 0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (tbl[i]) begin
      int k;
      k = tbl[i].sz ? KL : KS;
      set_one(tbl[i].kin);
      base = got_q.size();
      send_block(tbl[i].sz, k);
      idle();
      wait_out("vec", base + k);
      if (got_q.size() > base) check("vec_latency", gcyc_q[base] - last_acc, 3);
      check_block("vec", base, k, tbl[i].exp_idx);
    end

    // Back-to-back: A and B fill without stalls, C waits two cycles for A's bank to drain.
    base = got_q.size();
    e0   = err_cnt;
    set_one(2);    stalls = 0; send_block(1'b0, KS); sa = stalls;
    set_one(1055); stalls = 0; send_block(1'b0, KS); sb = stalls;
    set_one(1);    stalls = 0; send_block(1'b1, KL); sc = stalls;
    idle();
    check("b2b_stall_a", sa, 0);
    check("b2b_stall_b", sb, 0);
    check("b2b_stall_c", sc, 2);
    wait_out("b2b", base + 2 * KS + KL);
    check_block("b2b_a", base, KS, 298);
    check_block("b2b_b", base + KS, KS, 49);
    check_block("b2b_c", base + 2 * KS, KL, 743);
    if (got_q.size() > base + KS)
      check("b2b_gap", gcyc_q[base + KS] - gcyc_q[base + KS - 1], 1);
`ifdef DEINT_STATUS_EN
    check("b2b_err", err_cnt - e0, 2);
`endif

    // Abort a large block at k=500, restart as a small block.
    base = got_q.size();
    e0   = err_cnt;
    for (int i = 0; i < KL; i++) vec[i] = (i < 500);
    send_block(1'b1, 500);
    set_one(10);
    send_block(1'b0, KS);
    idle();
    wait_out("abort", base + KS);
    check_block("abort", base, KS, 434);
`ifdef DEINT_STATUS_EN
    check("abort_err", err_cnt - e0, 1);
`endif

    // Reset during a drain, then a clean block.
    base = got_q.size();
    set_one(3);
    send_block(1'b0, KS);
    idle();
    g = 0;
    while (got_q.size() < base + 300 && g < 5000) begin
      @(posedge clk_i);
      #1;
      g++;
    end
    check("mid_reached", int'(got_q.size() >= base + 300), 1);
    do_reset();
    base = got_q.size();
    set_one(1055);
    send_block(1'b0, KS);
    idle();
    wait_out("post_rst", base + KS);
    check_block("post_rst", base, KS, 49);

    // Loopback through a reference interleaver.
    do_reset();
    for (int s = 0; s < 2; s++) begin
      int k;
      k = s ? KL : KS;
      for (int n = 0; n < k; n++) expv[n] = 1'($urandom_range(0, 1));
      for (int i = 0; i < k; i++) vec[i] = expv[pi(i, s[0])];
      base = got_q.size();
      send_block(s[0], k);
      idle();
      wait_out("loop", base + k);
      check_block("loop", base, k, -1);
    end
`ifdef DEINT_STATUS_EN
    check("loop_blk_count", int'(blk_count_o), 2);
`endif

    check("done_total", done_pos.size(), 12);
    check("done_without_ready", bad_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
